// File: rtl/pc_sequencer_if.sv
// Bundle of sequencer control inputs and pipeline-front outputs.
// The master drives PC/hazard/stall inputs and the slave (sequencer) drives controls.
interface pc_sequencer_if #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
);
   logic              start_i;
   logic [ADDR_W-1:0] pc_i;
   logic              branch_taken_i;
   logic [ADDR_W-1:0] branch_target_i;
   logic              jump_i;
   logic [ADDR_W-1:0] jump_target_i;
   logic              idex_memread_i;
   logic [4:0]        idex_rt_i;
   logic [4:0]        ifid_rs_i;
   logic [4:0]        ifid_rt_i;
   logic              mem_stall_i;
   logic [ADDR_W-1:0] pc_next_o;
   logic              pc_write_o;
   logic              ifid_write_o;
   logic              ifid_flush_o;
   logic              idex_bubble_o;
   logic [1:0]        state_o;
   logic [CNT_W-1:0]  stall_cnt_o;

   modport master (
      output start_i, pc_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
             idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, mem_stall_i,
      input  pc_next_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
             state_o, stall_cnt_o
   );

   modport slave (
      input  start_i, pc_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
             idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, mem_stall_i,
      output pc_next_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
             state_o, stall_cnt_o
   );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC selection and IF/ID/EX front-end hold/flush/bubble control with a
// saturating stall-cycle counter for performance debug.
//
// state | meaning
// IDLE  | core halted, PC frozen at RESET_PC
// RUN   | normal fetch; detects mem stall and load-use hazard
// HAZ   | one cycle after a load-use bubble; hazard detect masked
// MEM   | frozen until data memory releases the pipeline
module pc_sequencer #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                CNT_W    = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   pc_sequencer_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HAZ  = 2'd2,
      S_MEM  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic [ADDR_W-1:0] w_pc_seq;
   logic [ADDR_W-1:0] w_pc_next;
   logic              w_pc_write;
   logic              w_ifid_write;
   logic              w_flush;
   logic              w_bubble;
   logic              w_load_use;
   logic              w_stall_inc;

   assign w_pc_seq   = bus.pc_i + ADDR_W'(4);
   assign w_load_use = (r_state == S_RUN) && bus.idex_memread_i && (bus.idex_rt_i != 5'd0) &&
                       ((bus.idex_rt_i == bus.ifid_rs_i) || (bus.idex_rt_i == bus.ifid_rt_i));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_pc_next    = w_pc_seq;
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_flush      = 1'b0;
      w_bubble     = 1'b0;
      w_stall_inc  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_pc_next = RESET_PC;
            if (bus.start_i) w_state_nxt = S_RUN;
         end
         S_RUN, S_HAZ: begin
            w_stall_inc = (r_state == S_HAZ);
            if (bus.mem_stall_i) begin
               w_stall_inc = 1'b1;
            end else if (w_load_use) begin
               w_bubble    = 1'b1;
               w_stall_inc = 1'b1;
            end else if (bus.jump_i) begin
               w_pc_next  = bus.jump_target_i;
               w_pc_write = 1'b1;
               w_flush    = 1'b1;
            end else if (bus.branch_taken_i) begin
               w_pc_next  = bus.branch_target_i;
               w_pc_write = 1'b1;
               w_flush    = 1'b1;
            end else begin
               w_pc_write   = 1'b1;
               w_ifid_write = 1'b1;
            end
            // A halt request wins over entering HAZ; the bubble still goes out this cycle.
            if (bus.mem_stall_i)  w_state_nxt = S_MEM;
            else if (!bus.start_i) w_state_nxt = S_IDLE;
            else if (w_load_use)   w_state_nxt = S_HAZ;
            else                   w_state_nxt = S_RUN;
         end
         S_MEM: begin
            w_stall_inc = 1'b1;
            if (!bus.mem_stall_i) w_state_nxt = bus.start_i ? S_RUN : S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         r_stall_cnt <= '0;
      else if ((r_state == S_IDLE) && bus.start_i)
         r_stall_cnt <= '0;
      else if (w_stall_inc && !(&r_stall_cnt))
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
   end

   assign bus.pc_next_o     = w_pc_next;
   assign bus.pc_write_o    = w_pc_write;
   assign bus.ifid_write_o  = w_ifid_write;
   assign bus.ifid_flush_o  = w_flush;
   assign bus.idex_bubble_o = w_bubble;
   assign bus.state_o       = r_state;
   assign bus.stall_cnt_o   = r_stall_cnt;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model predicts each cycle's
// outputs at stimulus time; a negedge monitor pops and compares.
module tb_pc_sequencer;
   localparam int ADDR_W = 32;
   localparam int CNT_W  = 4;
   localparam int CMAX   = (1 << CNT_W) - 1;
   localparam logic [31:0] RST_PC = 32'h0000_0080;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   always #5 clk_i = ~clk_i;

   pc_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

   pc_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   typedef struct {
      logic        rst_n;
      logic        start;
      logic [31:0] pc;
      logic        br;
      logic [31:0] bt;
      logic        jmp;
      logic [31:0] jt;
      logic        mr;
      logic [4:0]  xrt;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        ms;
   } stim_t;

   typedef struct {
      int          cyc;
      logic [31:0] pc_next;
      logic        pc_write;
      logic        ifid_write;
      logic        flush;
      logic        bubble;
      int          state;
      int          cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Model state: 0 idle, 1 running, 2 just bubbled, 3 waiting on memory.
   int m_mode = 0;
   int m_cnt  = 0;

   function automatic stim_t quiet(input logic start, input logic [31:0] pc);
      stim_t s;
      s.rst_n = 1'b1; s.start = start; s.pc = pc;
      s.br = 1'b0; s.bt = 32'h0; s.jmp = 1'b0; s.jt = 32'h0;
      s.mr = 1'b0; s.xrt = 5'd0; s.rs = 5'd0; s.rt = 5'd0; s.ms = 1'b0;
      return s;
   endfunction

   task automatic step(input stim_t s);
      exp_t e;
      bit   hazard;
      bit   stalled;
      int   nxt;
      @(posedge clk_i);
      #1;
      cyc++;
      rst_i                  = s.rst_n;
      bus.start_i            = s.start;
      bus.pc_i               = s.pc;
      bus.branch_taken_i     = s.br;
      bus.branch_target_i    = s.bt;
      bus.jump_i             = s.jmp;
      bus.jump_target_i      = s.jt;
      bus.idex_memread_i     = s.mr;
      bus.idex_rt_i          = s.xrt;
      bus.ifid_rs_i          = s.rs;
      bus.ifid_rt_i          = s.rt;
      bus.mem_stall_i        = s.ms;

      if (!s.rst_n) begin
         m_mode = 0;
         m_cnt  = 0;
      end
      e.cyc = cyc; e.pc_next = s.pc + 32'd4; e.pc_write = 0; e.ifid_write = 0;
      e.flush = 0; e.bubble = 0; e.state = m_mode; e.cnt = m_cnt;
      nxt = m_mode;
      stalled = 0;
      if (!s.rst_n) begin
         e.pc_next = RST_PC;
      end else if (m_mode == 0) begin
         e.pc_next = RST_PC;
         if (s.start) begin nxt = 1; m_cnt = 0; end
      end else if (m_mode == 3) begin
         stalled = 1;
         nxt = s.ms ? 3 : (s.start ? 1 : 0);
      end else begin
         hazard = (m_mode == 1) && s.mr && (s.xrt != 0) && (s.xrt == s.rs || s.xrt == s.rt);
         stalled = (m_mode == 2) || s.ms || hazard;
         if (s.ms) ;
         else if (hazard) e.bubble = 1;
         else if (s.jmp) begin e.pc_next = s.jt; e.pc_write = 1; e.flush = 1; end
         else if (s.br)  begin e.pc_next = s.bt; e.pc_write = 1; e.flush = 1; end
         else begin e.pc_write = 1; e.ifid_write = 1; end
         if (s.ms) nxt = 3;
         else if (!s.start) nxt = 0;
         else if (hazard) nxt = 2;
         else nxt = 1;
      end
      exp_q.push_back(e);
      if (s.rst_n) begin
         if (stalled && m_cnt < CMAX) m_cnt++;
         m_mode = nxt;
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.pc_write_o !== e.pc_write || bus.ifid_write_o !== e.ifid_write ||
                bus.ifid_flush_o !== e.flush || bus.idex_bubble_o !== e.bubble ||
                int'(bus.state_o) != e.state || int'(bus.stall_cnt_o) != e.cnt ||
                bus.pc_next_o !== e.pc_next) begin
               errors++;
               $display("FAIL cycle%0d outputs: got pcn=%h pw=%b iw=%b fl=%b bb=%b st=%0d cnt=%0d, need pcn=%h pw=%b iw=%b fl=%b bb=%b st=%0d cnt=%0d",
                        e.cyc, bus.pc_next_o, bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o,
                        bus.idex_bubble_o, bus.state_o, bus.stall_cnt_o, e.pc_next, e.pc_write,
                        e.ifid_write, e.flush, e.bubble, e.state, e.cnt);
            end
         end
      end
   end

   initial begin : stimulus
      stim_t s;
      logic [31:0] r;
      int wait_cyc;
      s = quiet(1'b0, 32'h0);
      s.rst_n = 1'b0;
      step(s);
      step(s);
      // Start from reset, sequential fetch at 0x100.
      s = quiet(1'b1, 32'h100);
      step(s);
      step(s);
      step(s);
      // Load-use on rs, then the HAZ cycle completes normally.
      s = quiet(1'b1, 32'h104); s.mr = 1; s.xrt = 5'd5; s.rs = 5'd5;
      step(s);
      s = quiet(1'b1, 32'h104);
      step(s);
      step(s);
      // Load to r0 never stalls.
      s = quiet(1'b1, 32'h108); s.mr = 1; s.xrt = 5'd0; s.rs = 5'd0; s.rt = 5'd0;
      step(s);
      // Load-use on rt.
      s = quiet(1'b1, 32'h10C); s.mr = 1; s.xrt = 5'd7; s.rt = 5'd7; s.rs = 5'd1;
      step(s);
      // Branch and jump together; jump wins.
      s = quiet(1'b1, 32'h110); s.br = 1; s.bt = 32'h200; s.jmp = 1; s.jt = 32'h400;
      step(s);
      s = quiet(1'b1, 32'h400); s.br = 1; s.bt = 32'h800;
      step(s);
      // Three stall cycles, halt requested from the second one.
      s = quiet(1'b1, 32'h800); s.ms = 1;
      step(s);
      s.start = 0;
      step(s);
      step(s);
      s = quiet(1'b0, 32'h800);
      step(s);
      step(s);
      // Restart and wrap the sequential PC.
      s = quiet(1'b1, 32'hFFFF_FFFC);
      step(s);
      step(s);
      step(s);
      // Reset asserted while frozen on memory.
      s.ms = 1;
      step(s);
      step(s);
      s = quiet(1'b1, 32'h0); s.rst_n = 1'b0; s.ms = 1;
      step(s);
      s = quiet(1'b1, 32'h0);
      step(s);
      step(s);
      // Long memory stall drives the counter into saturation.
      s.ms = 1;
      for (int i = 0; i < CMAX + 4; i++) step(s);
      s.ms = 0;
      step(s);
      step(s);
      // Randomised traffic.
      for (int i = 0; i < 600; i++) begin
         r = $urandom();
         s = quiet(($urandom_range(0, 9) != 0), r & 32'hFFFF_FFFC);
         if ($urandom_range(0, 15) == 0) s.pc = 32'hFFFF_FFFC;
         s.br  = ($urandom_range(0, 3) == 0);
         r = $urandom(); s.bt = r & 32'hFFFF_FFFC;
         s.jmp = ($urandom_range(0, 4) == 0);
         r = $urandom(); s.jt = r & 32'hFFFF_FFFC;
         s.mr  = ($urandom_range(0, 2) == 0);
         s.xrt = 5'($urandom_range(0, 3));
         s.rs  = 5'($urandom_range(0, 3));
         s.rt  = 5'($urandom_range(0, 3));
         s.ms  = ($urandom_range(0, 7) == 0);
         s.rst_n = ($urandom_range(0, 199) != 0);
         step(s);
      end
      wait_cyc = 0;
      while (exp_q.size() > 0 && wait_cyc < 20) begin
         @(posedge clk_i);
         wait_cyc++;
      end
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
